// File: rtl/uart_rx_async.sv
// uart_rx_async: asynchronous serial receiver with 16x oversampling.
// It recovers 7- or 8-bit frames, LSB first, with optional parity checking.
// The rx line passes through a two-flop synchronizer. Every sample is taken
// from the synchronized signal on a baud_clock strobe.
//
// Parameter RX_FIFO selects how a completed byte is delivered:
//   RX_FIFO = 0 : the byte goes to a holding register. rx_ready is set, and
//                 overflow pulses if the previous byte was never read.
//   RX_FIFO = 1 : a one-clk fifo_write strobe is issued. When fifo_full is
//                 set, the write is dropped and overflow pulses instead.
// Define the macro RX_FRAMING_ERR_EN to build the sticky framing_err flag
// and break protection. Without it, framing_err is tied 0 and the stop bit
// value is ignored.
//
// Ports:
//   clk, aresetn        clock; asynchronous active-low reset
//   baud_clock          16x-baud enable strobe, one clk wide
//   rx                  asynchronous serial input, idle high
//   bit8, parity_en,    frame format, sampled live
//   odd_n_even
//   read_rx_byte        CPU read pulse, clears rx_ready
//   clear_parity        clears parity_err
//   clear_framing       clears framing_err (macro build only)
//   fifo_full           RX FIFO full (RX_FIFO = 1)
//   rx_byte             last received byte, right-justified in 7-bit mode
//   rx_ready            byte available (RX_FIFO = 0)
//   fifo_write          write strobe; rx_byte is valid in the same cycle
//   parity_err          sticky parity error
//   overflow            one-clk pulse when a byte is lost
//   framing_err         sticky stop-bit error
module uart_rx_async #(
  parameter int unsigned RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_parity,
  input  logic       clear_framing,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       fifo_write,
  output logic       parity_err,
  output logic       overflow,
  output logic       framing_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] samp_q, samp_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       perr_pend_q, perr_pend_d;

  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_ready_q, rx_ready_d;
  logic       fifo_write_q, fifo_write_d;
  logic       parity_err_q, parity_err_d;
  logic       overflow_q, overflow_d;

  logic       done;      // frame completes this clk
  logic       stop_low;  // stop bit sampled as 0 at completion
  logic       start_ok;
  logic [3:0] last_bit;
  logic [7:0] byte_data;

  // Synchronizer flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign last_bit  = bit8 ? 4'd7 : 4'd6;
  // In 7-bit mode only seven shifts occur, so the data sits in shift_q[7:1].
  assign byte_data = bit8 ? shift_q : {1'b0, shift_q[7:1]};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    perr_pend_d = perr_pend_q;
    done        = 1'b0;
    stop_low    = 1'b0;
    if (baud_clock) begin
      samp_d = samp_q + 4'd1;
      case (state_q)
        IDLE: begin
          if (!rx_s_q && start_ok) begin
            state_d = START;
            samp_d  = '0;
          end
        end
        START: begin
          if (samp_q == 4'd7) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d     = DATA;
              samp_d      = '0;
              bit_d       = '0;
              par_d       = 1'b0;
              perr_pend_d = 1'b0;
            end
          end
        end
        DATA: begin
          if (samp_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            par_d   = par_q ^ rx_s_q;
            bit_d   = bit_q + 4'd1;
            if (bit_q == last_bit) begin
              state_d = parity_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (samp_q == 4'd15) begin
            if ((rx_s_q ^ par_q) != odd_n_even) begin
              perr_pend_d = 1'b1;
            end
            state_d = STOP;
          end
        end
        STOP: begin
          if (samp_q == 4'd15) begin
            done     = 1'b1;
            stop_low = ~rx_s_q;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Delivery. A read in the same clk as completion is overridden by the new byte.
  always_comb begin
    rx_byte_d    = done ? byte_data : rx_byte_q;
    parity_err_d = (parity_err_q & ~clear_parity) | (done & perr_pend_q);
    rx_ready_d   = 1'b0;
    fifo_write_d = 1'b0;
    overflow_d   = 1'b0;
    if (RX_FIFO == 0) begin
      rx_ready_d = done | (rx_ready_q & ~read_rx_byte);
      overflow_d = done & rx_ready_q & ~read_rx_byte;
    end else begin
      fifo_write_d = done & ~fifo_full;
      overflow_d   = done & fifo_full;
    end
  end

  // fifo_write is registered so that it coincides with the updated rx_byte.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_byte_q    <= '0;
      rx_ready_q   <= 1'b0;
      fifo_write_q <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rx_byte_q    <= rx_byte_d;
      rx_ready_q   <= rx_ready_d;
      fifo_write_q <= fifo_write_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef RX_FRAMING_ERR_EN
  logic brk_q, brk_d;
  logic framing_err_q, framing_err_d;

  // A low stop bit arms break protection. A new start is refused until the line is seen high again.
  always_comb begin
    brk_d = brk_q;
    if (rx_s_q) begin
      brk_d = 1'b0;
    end
    if (done && stop_low) begin
      brk_d = 1'b1;
    end
    framing_err_d = (framing_err_q & ~clear_framing) | (done & stop_low);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      brk_q         <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      brk_q         <= brk_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign start_ok    = ~brk_q;
  assign framing_err = framing_err_q;
`else
  logic unused_framing;
  assign unused_framing = clear_framing ^ stop_low;
  assign start_ok       = 1'b1;
  assign framing_err    = 1'b0;
`endif

  assign rx_byte    = rx_byte_q;
  assign rx_ready   = rx_ready_q;
  assign fifo_write = fifo_write_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_async.sv
module tb_uart_rx_async;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic baud_clock = 1'b0;
  logic rx = 1'b1;
  logic bit8 = 1'b1;
  logic parity_en = 1'b0;
  logic odd_n_even = 1'b0;
  logic read_rx_byte = 1'b0;
  logic clear_parity = 1'b0;
  logic clear_framing = 1'b0;
  logic fifo_full0 = 1'b0;
  logic fifo_full1 = 1'b0;

  logic [7:0] rx_byte0, rx_byte1;
  logic rx_ready0, rx_ready1, fifo_write0, fifo_write1;
  logic parity_err0, parity_err1, overflow0, overflow1, framing_err0, framing_err1;

  int vectors = 0;
  int miscompares = 0;

  int ovf0_n = 0;
  int ovf1_n = 0;
  int fw1_n = 0;
  logic [7:0] fw1_byte = 8'h00;

  int s_ovf0, s_ovf1, s_fw1;

  uart_rx_async #(.RX_FIFO(0)) u0 (
    .clk(clk), .aresetn(aresetn), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
    .clear_framing(clear_framing), .fifo_full(fifo_full0),
    .rx_byte(rx_byte0), .rx_ready(rx_ready0), .fifo_write(fifo_write0),
    .parity_err(parity_err0), .overflow(overflow0), .framing_err(framing_err0)
  );

  uart_rx_async #(.RX_FIFO(1)) u1 (
    .clk(clk), .aresetn(aresetn), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
    .clear_framing(clear_framing), .fifo_full(fifo_full1),
    .rx_byte(rx_byte1), .rx_ready(rx_ready1), .fifo_write(fifo_write1),
    .parity_err(parity_err1), .overflow(overflow1), .framing_err(framing_err1)
  );

  always #5 clk = ~clk;

  // 16x strobe: one clk out of every four, so one bit time is 64 clks.
  int div = 0;
  always @(negedge clk) begin
    div = (div + 1) % 4;
    baud_clock = (div == 0);
  end

  // Pulse monitors for single-cycle outputs.
  always @(negedge clk) begin
    if (overflow0 === 1'b1) ovf0_n++;
    if (overflow1 === 1'b1) ovf1_n++;
    if (fifo_write1 === 1'b1) begin
      fw1_n++;
      fw1_byte = rx_byte1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame. If stop_rel is set, the stop level is driven for only 44 clks
  // (past the receiver's stop sample) and the line then returns high.
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                            input logic pbit, input logic stopv, input logic stop_rel);
    rx = 1'b0;
    hold(64);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      hold(64);
    end
    if (has_par) begin
      rx = pbit;
      hold(64);
    end
    rx = stopv;
    if (stop_rel) begin
      hold(44);
      rx = 1'b1;
      hold(20);
    end else begin
      hold(64);
    end
  endtask

  task automatic read_pulse();
    read_rx_byte = 1'b1;
    hold(1);
    read_rx_byte = 1'b0;
    hold(1);
  endtask

  initial begin
    // Reset state
    hold(5);
    check("rst_rx_byte", rx_byte0, 8'h00);
    check("rst_rx_ready", {7'd0, rx_ready0}, 8'h00);
    check("rst_overflow", {7'd0, overflow0}, 8'h00);
    check("rst_parity_err", {7'd0, parity_err0}, 8'h00);
    check("rst_framing_err", {7'd0, framing_err0}, 8'h00);
    check("rst_fifo_write", {7'd0, fifo_write1}, 8'h00);
    aresetn = 1'b1;
    hold(20);

    // 8N1 0xA5
    s_fw1 = fw1_n; s_ovf0 = ovf0_n;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    hold(8);
    check("a5_rx_byte", rx_byte0, 8'hA5);
    check("a5_rx_ready", {7'd0, rx_ready0}, 8'h01);
    check("a5_no_ovf", 8'(ovf0_n - s_ovf0), 8'h00);
    check("a5_fifo_writes", 8'(fw1_n - s_fw1), 8'h01);
    check("a5_fifo_byte", fw1_byte, 8'hA5);
    check("a5_fifo_no_ready", {7'd0, rx_ready1}, 8'h00);
    check("a5_hold_no_write", {7'd0, fifo_write0}, 8'h00);
    read_pulse();
    check("a5_read_clears", {7'd0, rx_ready0}, 8'h00);

    // 7E1, 0x55 has four ones: even parity bit is 0
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    hold(8);
    check("p_ok_rx_byte", rx_byte0, 8'h55);
    check("p_ok_parity_err", {7'd0, parity_err0}, 8'h00);
    read_pulse();
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    hold(8);
    check("p_bad_rx_byte", rx_byte0, 8'h55);
    check("p_bad_parity_err", {7'd0, parity_err0}, 8'h01);
    hold(40);
    check("p_bad_sticky", {7'd0, parity_err0}, 8'h01);
    clear_parity = 1'b1;
    hold(1);
    clear_parity = 1'b0;
    hold(1);
    check("p_cleared", {7'd0, parity_err0}, 8'h00);
    read_pulse();
    bit8 = 1'b1; parity_en = 1'b0;

    // Two frames without a read in between
    s_ovf0 = ovf0_n; s_fw1 = fw1_n;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(8);
    check("ovf_count", 8'(ovf0_n - s_ovf0), 8'h01);
    check("ovf_rx_byte", rx_byte0, 8'h22);
    check("ovf_rx_ready", {7'd0, rx_ready0}, 8'h01);
    check("ovf_fifo_writes", 8'(fw1_n - s_fw1), 8'h02);
    read_pulse();

    // Low glitch of 4 baud ticks in IDLE, then a real frame
    s_fw1 = fw1_n;
    rx = 1'b0;
    hold(16);
    rx = 1'b1;
    hold(200);
    check("glitch_no_ready", {7'd0, rx_ready0}, 8'h00);
    check("glitch_no_write", 8'(fw1_n - s_fw1), 8'h00);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(8);
    check("glitch_next_byte", rx_byte0, 8'h3C);
    check("glitch_next_ready", {7'd0, rx_ready0}, 8'h01);
    read_pulse();

    // FIFO delivery, then FIFO full
    s_fw1 = fw1_n; s_ovf1 = ovf1_n;
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(8);
    check("fifo_write_count", 8'(fw1_n - s_fw1), 8'h01);
    check("fifo_write_byte", fw1_byte, 8'hF0);
    check("fifo_no_ovf", 8'(ovf1_n - s_ovf1), 8'h00);
    read_pulse();
    fifo_full1 = 1'b1;
    s_fw1 = fw1_n; s_ovf1 = ovf1_n;
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(8);
    check("full_no_write", 8'(fw1_n - s_fw1), 8'h00);
    check("full_ovf", 8'(ovf1_n - s_ovf1), 8'h01);
    check("full_hold_byte", rx_byte0, 8'h0F);
    fifo_full1 = 1'b0;
    read_pulse();

    // Reset in the middle of a frame
    s_fw1 = fw1_n; s_ovf0 = ovf0_n;
    rx = 1'b0;
    hold(64);
    rx = 1'b1;
    hold(64);
    aresetn = 1'b0;
    hold(3);
    aresetn = 1'b1;
    hold(1300);
    check("midrst_rx_byte", rx_byte0, 8'h00);
    check("midrst_no_ready", {7'd0, rx_ready0}, 8'h00);
    check("midrst_no_write", 8'(fw1_n - s_fw1), 8'h00);
    check("midrst_no_ovf", 8'(ovf0_n - s_ovf0), 8'h00);

    // Stop bit driven low on 0x81
    s_fw1 = fw1_n;
`ifdef RX_FRAMING_ERR_EN
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(4);
    check("ferr_set", {7'd0, framing_err0}, 8'h01);
    check("ferr_rx_byte", rx_byte0, 8'h81);
    check("ferr_rx_ready", {7'd0, rx_ready0}, 8'h01);
    read_pulse();
    hold(300);
    check("brk_no_ready", {7'd0, rx_ready0}, 8'h00);
    check("brk_one_write", 8'(fw1_n - s_fw1), 8'h01);
    rx = 1'b1;
    hold(100);
    check("ferr_sticky", {7'd0, framing_err0}, 8'h01);
    clear_framing = 1'b1;
    hold(1);
    clear_framing = 1'b0;
    hold(1);
    check("ferr_cleared", {7'd0, framing_err0}, 8'h00);
`else
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    hold(8);
    check("stop0_no_ferr", {7'd0, framing_err0}, 8'h00);
    check("stop0_rx_byte", rx_byte0, 8'h81);
    check("stop0_rx_ready", {7'd0, rx_ready0}, 8'h01);
    read_pulse();
    hold(100);
    check("stop0_one_write", 8'(fw1_n - s_fw1), 8'h01);
`endif
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(8);
    check("after_stop0_byte", rx_byte0, 8'h5A);
    check("after_stop0_ready", {7'd0, rx_ready0}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
